// File: rtl/tx_token_arbiter_pkg.sv
// Shared packet layout, type codes and arbiter state encoding for the TX token arbiter.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package tx_token_arbiter_pkg;

    // Packet and address geometry used by every path through the router.
    localparam int PKT_W      = 55;
    localparam int RTR_ADDR_W = 4;

    // Packet field positions: [54:53] type, [52:49] dst, [48:45] src, [44:0] payload.
    localparam int TYPE_MSB = 54;
    localparam int TYPE_LSB = 53;
    localparam int DST_MSB  = 52;
    localparam int DST_LSB  = 49;
    localparam int SRC_MSB  = 48;
    localparam int SRC_LSB  = 45;

    // Packet type codes.
    localparam logic [1:0] TYPE_DATA  = 2'b01;
    localparam logic [1:0] TYPE_TOKEN = 2'b11;

    // IDLE/HOLD are the only states in which a new packet may be chosen.
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_HOLD       = 3'd1,
        ST_XMIT_FWD   = 3'd2,
        ST_XMIT_LOCAL = 3'd3,
        ST_XMIT_TOKEN = 3'd4
    } arb_state_t;

endpackage

// File: rtl/tx_token_arbiter.sv
// Shares the single serial TX channel between forwarded ring traffic and token-gated local injection.
// Latency: packet captured in cycle N is presented on TX_Data with TX_Data_Valid in cycle N+1.
// Backpressure: TX_Data held stable until TX_Data_Ready; no new capture until the cycle after the handshake.
module tx_token_arbiter
    import tx_token_arbiter_pkg::*;
#(
    parameter int               DATA_W    = PKT_W,
    parameter int               ADDR_W    = RTR_ADDR_W,
    parameter int               MAX_BURST = 4,
    parameter int               HOLD_MAX  = 64,
    parameter logic [ADDR_W-1:0] INIT_ADDR = '0
) (
    input  logic              Clk_R,
    input  logic              Rst,
    input  logic [ADDR_W-1:0] r_addr,
    input  logic              Fwd_Valid,
    input  logic [DATA_W-1:0] Fwd_Data,
    output logic              Fwd_Ready,
    input  logic              Local_Valid,
    input  logic [DATA_W-1:0] Local_Data,
    output logic              Local_Ack,
    input  logic              Token_In,
    input  logic              TX_Data_Ready,
    output logic              TX_Data_Valid,
    output logic [DATA_W-1:0] TX_Data,
    output logic              Token_Held,
    output logic              Token_Dup
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int HW = $clog2(HOLD_MAX + 1);
    localparam logic [BW-1:0] BURST_LIM = BW'(MAX_BURST);
    localparam logic [HW-1:0] HOLD_LIM  = HW'(HOLD_MAX);

    arb_state_t        state;
    logic              token_held;
    logic              token_dup;
    logic [BW-1:0]     burst_cnt;
    logic [HW-1:0]     hold_cnt;
    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;

    logic              deciding;
    logic              take_fwd;
    logic              take_local;
    logic              take_token;
    logic              tx_done;
    logic              token_acquire;
    logic              token_release;
    logic [DATA_W-1:0] token_pkt;

    // Arbitration decision for this cycle: forward always wins, locals only under the token and within limits.
    always_comb begin
        deciding      = (state == ST_IDLE) || (state == ST_HOLD);
        take_fwd      = deciding && Fwd_Valid;
        take_local    = (state == ST_HOLD) && !Fwd_Valid && Local_Valid &&
                        (burst_cnt < BURST_LIM) && (hold_cnt < HOLD_LIM);
        take_token    = (state == ST_HOLD) && !take_fwd && !take_local;
        tx_done       = tx_valid && TX_Data_Ready;
        token_release = tx_done && (state == ST_XMIT_TOKEN);
        // A duplicate arriving while the release is in flight is still a duplicate: token_held is 1 then.
        token_acquire = Token_In && !token_held;
    end

    // Token packet addressed to the next router on the ring, sourced from this one.
    always_comb begin
        token_pkt                    = '0;
        token_pkt[TYPE_MSB:TYPE_LSB] = TYPE_TOKEN;
        token_pkt[DST_MSB:DST_LSB]   = r_addr + ADDR_W'(1);
        token_pkt[SRC_MSB:SRC_LSB]   = r_addr;
    end

    // Channel FSM with registered TX output; a reset drops whatever was in flight.
    always_ff @(posedge Clk_R) begin
        if (Rst) begin
            state    <= (r_addr == INIT_ADDR) ? ST_HOLD : ST_IDLE;
            tx_valid <= 1'b0;
            tx_data  <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_HOLD: begin
                    if (take_fwd) begin
                        tx_data  <= Fwd_Data;
                        tx_valid <= 1'b1;
                        state    <= ST_XMIT_FWD;
                    end else if (take_local) begin
                        tx_data  <= Local_Data;
                        tx_valid <= 1'b1;
                        state    <= ST_XMIT_LOCAL;
                    end else if (take_token) begin
                        tx_data  <= token_pkt;
                        tx_valid <= 1'b1;
                        state    <= ST_XMIT_TOKEN;
                    end else if (token_acquire) begin
                        state    <= ST_HOLD;
                    end
                end
                ST_XMIT_FWD: begin
                    if (tx_done) begin
                        tx_valid <= 1'b0;
                        // A token landing on the handshake cycle must still bring us back to HOLD.
                        state    <= (token_held || token_acquire) ? ST_HOLD : ST_IDLE;
                    end
                end
                ST_XMIT_LOCAL: begin
                    if (tx_done) begin
                        tx_valid <= 1'b0;
                        state    <= ST_HOLD;
                    end
                end
                ST_XMIT_TOKEN: begin
                    if (tx_done) begin
                        tx_valid <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: begin
                    tx_valid <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

    // Token ownership, duplicate detection, local burst count and hold-time count.
    always_ff @(posedge Clk_R) begin
        if (Rst) begin
            token_held <= (r_addr == INIT_ADDR);
            token_dup  <= 1'b0;
            burst_cnt  <= '0;
            hold_cnt   <= '0;
        end else begin
            token_dup <= Token_In && token_held;
            if (token_release) begin
                token_held <= 1'b0;
                burst_cnt  <= '0;
                hold_cnt   <= '0;
            end else if (token_acquire) begin
                token_held <= 1'b1;
                burst_cnt  <= '0;
                hold_cnt   <= '0;
            end else begin
                if (token_held && (hold_cnt < HOLD_LIM)) begin
                    hold_cnt <= hold_cnt + HW'(1);
                end
                if (take_local) begin
                    burst_cnt <= burst_cnt + BW'(1);
                end
            end
        end
    end

    assign Fwd_Ready     = take_fwd;
    assign Local_Ack     = take_local;
    assign TX_Data_Valid = tx_valid;
    assign TX_Data       = tx_data;
    assign Token_Held    = token_held;
    assign Token_Dup     = token_dup;

endmodule

// File: tb/tb_tx_token_arbiter.sv
// Randomized bench for tx_token_arbiter against a transaction-level model of the channel and token.
// Latency: model predicts every output every cycle.
// Backpressure: TX_Data_Ready randomized per phase, including long stalls.
module tb_tx_token_arbiter;

    localparam int DW = 55;
    localparam int AW = 4;
    localparam int MB = 4;
    localparam int HM = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] r_addr;
    logic          fwd_valid;
    logic [DW-1:0] fwd_data;
    logic          fwd_ready;
    logic          local_valid;
    logic [DW-1:0] local_data;
    logic          local_ack;
    logic          token_in;
    logic          tx_ready;
    logic          tx_valid;
    logic [DW-1:0] tx_data;
    logic          token_held;
    logic          token_dup;

    always #5 clk = ~clk;

    tx_token_arbiter #(
        .DATA_W(DW), .ADDR_W(AW), .MAX_BURST(MB), .HOLD_MAX(HM), .INIT_ADDR(4'd0)
    ) dut (
        .Clk_R(clk), .Rst(rst), .r_addr(r_addr),
        .Fwd_Valid(fwd_valid), .Fwd_Data(fwd_data), .Fwd_Ready(fwd_ready),
        .Local_Valid(local_valid), .Local_Data(local_data), .Local_Ack(local_ack),
        .Token_In(token_in), .TX_Data_Ready(tx_ready),
        .TX_Data_Valid(tx_valid), .TX_Data(tx_data),
        .Token_Held(token_held), .Token_Dup(token_dup)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: link busy with one packet or free; token owned with burst/hold tallies.
    bit            m_held;
    bit            m_busy;
    int            m_kind;   // 0 forward, 1 local, 2 token
    logic [DW-1:0] m_pkt;
    int            m_bursts;
    int            m_hc;
    bit            m_dup;
    bit            fwd_cap;
    bit            loc_cap;

    // Phase knobs (percentages)
    int p_fwd, p_loc, p_rdy, p_tok, p_rst;

    function automatic logic [DW-1:0] tok_pkt(input int a);
        logic [DW-1:0] p;
        p = DW'(3) << 53;
        p = p | (DW'((a + 1) % 16) << 49);
        p = p | (DW'(a) << 45);
        return p;
    endfunction

    function automatic logic [DW-1:0] rnd_pkt();
        logic [63:0] w;
        w = {$urandom(), $urandom()};
        return w[DW-1:0];
    endfunction

    task automatic do_reset(input logic [AW-1:0] addr);
        rst         = 1'b1;
        r_addr      = addr;
        fwd_valid   = 1'b0;
        local_valid = 1'b0;
        token_in    = 1'b0;
        tx_ready    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst      = 1'b0;
        m_held   = (addr == 4'd0);
        m_busy   = 1'b0;
        m_kind   = 0;
        m_pkt    = '0;
        m_bursts = 0;
        m_hc     = 0;
        m_dup    = 1'b0;
        fwd_cap  = 1'b0;
        loc_cap  = 1'b0;
        #1;
        check_eq("rst_tx_valid", 64'(tx_valid), 64'(0));
        check_eq("rst_tx_data", 64'(tx_data), 64'(0));
        check_eq("rst_token_held", 64'(token_held), 64'(addr == 4'd0));
        check_eq("rst_token_dup", 64'(token_dup), 64'(0));
    endtask

    // One cycle: drive inputs just after the falling edge, check, advance the model to the next rising edge.
    task automatic run_cycle(input bit flood);
        bit exp_fr, exp_la, rel, old_held, n_dup;
        if (fwd_cap || !fwd_valid) begin
            fwd_valid = flood || ($urandom_range(99) < p_fwd);
            fwd_data  = rnd_pkt();
        end
        if (loc_cap || !local_valid) begin
            local_valid = ($urandom_range(99) < p_loc);
            local_data  = rnd_pkt();
        end
        tx_ready = ($urandom_range(99) < p_rdy);
        token_in = ($urandom_range(99) < p_tok);
        #1;
        exp_fr = !m_busy && fwd_valid;
        exp_la = !m_busy && m_held && !fwd_valid && local_valid && (m_bursts < MB) && (m_hc < HM);
        check_eq("fwd_ready", 64'(fwd_ready), 64'(exp_fr));
        check_eq("local_ack", 64'(local_ack), 64'(exp_la));
        check_eq("tx_valid", 64'(tx_valid), 64'(m_busy));
        if (m_busy) check_eq("tx_data", 64'(tx_data), 64'(m_pkt));
        check_eq("token_held", 64'(token_held), 64'(m_held));
        check_eq("token_dup", 64'(token_dup), 64'(m_dup));

        fwd_cap  = 1'b0;
        loc_cap  = 1'b0;
        old_held = m_held;
        n_dup    = token_in && m_held;
        rel      = m_busy && tx_ready && (m_kind == 2);
        if (m_busy) begin
            if (tx_ready) m_busy = 1'b0;
        end else if (fwd_valid) begin
            m_busy = 1'b1; m_kind = 0; m_pkt = fwd_data; fwd_cap = 1'b1;
        end else if (exp_la) begin
            m_busy = 1'b1; m_kind = 1; m_pkt = local_data; loc_cap = 1'b1;
            m_bursts++;
        end else if (m_held) begin
            m_busy = 1'b1; m_kind = 2; m_pkt = tok_pkt(int'(r_addr));
        end
        if (rel) begin
            m_held = 1'b0; m_bursts = 0; m_hc = 0;
        end else if (token_in && !old_held) begin
            m_held = 1'b1; m_bursts = 0; m_hc = 0;
        end else if (old_held && m_hc < HM) begin
            m_hc++;
        end
        m_dup = n_dup;
        @(negedge clk);
    endtask

    initial begin
        logic [AW-1:0] addr;
        int            ncyc;
        int            flood_len;
        rst = 1'b1; r_addr = '0; fwd_valid = 1'b0; fwd_data = '0; local_valid = 1'b0;
        local_data = '0; token_in = 1'b0; tx_ready = 1'b0;
        fwd_cap = 1'b0; loc_cap = 1'b0;
        @(negedge clk);
        for (int ph = 0; ph < 8; ph++) begin
            ncyc = 1200; flood_len = 0; p_rst = 0;
            case (ph)
                0: begin addr = 4'd0;  p_fwd = 0;  p_loc = 0;   p_rdy = 100; p_tok = 0;  ncyc = 200; end
                1: begin addr = 4'd3;  p_fwd = 0;  p_loc = 100; p_rdy = 100; p_tok = 5;  end
                2: begin addr = 4'd5;  p_fwd = 30; p_loc = 50;  p_rdy = 60;  p_tok = 10; end
                3: begin addr = 4'd15; p_fwd = 40; p_loc = 40;  p_rdy = 8;   p_tok = 5;  end
                4: begin addr = 4'd7;  p_fwd = 20; p_loc = 100; p_rdy = 70;  p_tok = 3;  flood_len = 250; end
                5: begin addr = 4'd0;  p_fwd = 15; p_loc = 100; p_rdy = 50;  p_tok = 10; flood_len = 150; end
                6: begin addr = 4'd9;  p_fwd = 35; p_loc = 60;  p_rdy = 60;  p_tok = 8;  p_rst = 2; end
                default: begin
                    addr  = 4'($urandom_range(15));
                    p_fwd = $urandom_range(60); p_loc = $urandom_range(100);
                    p_rdy = 10 + $urandom_range(90); p_tok = $urandom_range(15); p_rst = 1;
                    ncyc  = 2000;
                end
            endcase
            do_reset(addr);
            for (int c = 0; c < ncyc; c++) begin
                if (p_rst != 0 && $urandom_range(99) < p_rst) do_reset(addr);
                else run_cycle(c < flood_len);
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
